// File: rtl/imem_loadable.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loadable
//  Purpose  : Instruction memory with a registered 1-cycle fetch port, a
//             valid/ready streaming program-load port, and a post-reset
//             fill of every word with NOP_WORD.
//  Option   : define IMEM_FAULT_EN to add fetch_fault_o, which flags
//             misaligned or out-of-range fetch addresses.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_loadable #(
   parameter int                ADDR_W   = 32,
   parameter int                DEPTH    = 256,
   parameter int                DATA_W   = 32,
   parameter logic [DATA_W-1:0] NOP_WORD = 32'h00000013
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       fetch_req_i,
   input  logic [ADDR_W-1:0]          fetch_addr_i,
   output logic                       fetch_ready_o,
   output logic                       fetch_valid_o,
   output logic [DATA_W-1:0]          fetch_instr_o,
`ifdef IMEM_FAULT_EN
   output logic                       fetch_fault_o,
`endif
   input  logic                       load_start_i,
   input  logic [ADDR_W-1:0]          load_base_i,
   input  logic [$clog2(DEPTH):0]     load_len_i,
   input  logic                       load_valid_i,
   input  logic [DATA_W-1:0]          load_data_i,
   output logic                       load_ready_o,
   output logic                       load_done_o,
   output logic                       busy_o
);

   localparam int IW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_CLEAR = 2'd0,
      S_RUN   = 2'd1,
      S_LOAD  = 2'd2
   } state_t;

   // Storage and control state
   logic [DATA_W-1:0] mem_q [DEPTH];
   state_t            state_q,     state_d;
   logic [IW-1:0]     clr_cnt_q,   clr_cnt_d;
   logic [IW-1:0]     ptr_q,       ptr_d;
   logic [IW:0]       rem_q,       rem_d;
   logic              load_done_q, load_done_d;
   logic              fetch_valid_q;
   logic [DATA_W-1:0] fetch_instr_q;

   // Single memory write port shared by the clear walker and the loader
   logic              w_mem_we;
   logic [IW-1:0]     w_mem_waddr;
   logic [DATA_W-1:0] w_mem_wdata;

   logic              w_fetch_acc;
   logic [IW-1:0]     w_fetch_idx;
   logic              w_fetch_fault;

   // Address bits outside the word index are intentionally dropped
   logic              w_unused;
   assign w_unused = &{1'b0, fetch_addr_i, load_base_i, 1'b0};

   assign w_fetch_acc = fetch_req_i && (state_q == S_RUN);
   assign w_fetch_idx = fetch_addr_i[IW+1:2];

`ifdef IMEM_FAULT_EN
   logic fetch_fault_q;
   assign w_fetch_fault = (fetch_addr_i[1:0] != 2'b00) ||
                          ({1'b0, fetch_addr_i} >= (ADDR_W+1)'(DEPTH*4));
   assign fetch_fault_o = fetch_fault_q;
`else
   assign w_fetch_fault = 1'b0;
`endif

   assign fetch_ready_o = (state_q == S_RUN);
   assign load_ready_o  = (state_q == S_LOAD);
   assign busy_o        = (state_q != S_RUN);
   assign load_done_o   = load_done_q;
   assign fetch_valid_o = fetch_valid_q;
   assign fetch_instr_o = fetch_instr_q;

   // Control state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_CLEAR;
         clr_cnt_q   <= '0;
         ptr_q       <= '0;
         rem_q       <= '0;
         load_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         ptr_q       <= ptr_d;
         rem_q       <= rem_d;
         load_done_q <= load_done_d;
      end
   end

   // Next-state logic and memory write-port steering
   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      ptr_d       = ptr_q;
      rem_d       = rem_q;
      load_done_d = 1'b0;
      w_mem_we    = 1'b0;
      w_mem_waddr = clr_cnt_q;
      w_mem_wdata = NOP_WORD;
      case (state_q)
         S_CLEAR: begin
            w_mem_we    = 1'b1;
            w_mem_waddr = clr_cnt_q;
            w_mem_wdata = NOP_WORD;
            // Wraps back to zero on the last word, ready for the next reset
            clr_cnt_d   = clr_cnt_q + 1'b1;
            if (clr_cnt_q == IW'(DEPTH-1)) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (load_start_i) begin
               if (load_len_i == '0) begin
                  load_done_d = 1'b1;
               end else begin
                  ptr_d   = load_base_i[IW+1:2];
                  rem_d   = load_len_i;
                  state_d = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            if (load_valid_i) begin
               w_mem_we    = 1'b1;
               w_mem_waddr = ptr_q;
               w_mem_wdata = load_data_i;
               ptr_d       = ptr_q + 1'b1;
               rem_d       = rem_q - 1'b1;
               if (rem_q == (IW+1)'(1)) begin
                  state_d     = S_RUN;
                  load_done_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_CLEAR;
         end
      endcase
   end

   // Memory array write; contents are initialised by the clear walk
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         mem_q[w_mem_waddr] <= w_mem_wdata;
      end
   end

   // Registered fetch read; faulting fetches return NOP without a read
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_valid_q <= 1'b0;
         fetch_instr_q <= NOP_WORD;
`ifdef IMEM_FAULT_EN
         fetch_fault_q <= 1'b0;
`endif
      end else begin
         fetch_valid_q <= w_fetch_acc;
`ifdef IMEM_FAULT_EN
         fetch_fault_q <= w_fetch_acc && w_fetch_fault;
`endif
         if (w_fetch_acc) begin
            fetch_instr_q <= w_fetch_fault ? NOP_WORD : mem_q[w_fetch_idx];
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
Parametrised successor to the core's hard-coded instruction memory. It gives the fetch stage a registered, word-aligned instruction read port with a 1-cycle latency. A streaming valid/ready program-load port lets a host or boot loader write a block of words at runtime. After reset, an internal FSM walks the whole array and fills it with a NOP, so no reset-time multi-word assignment is needed.

Parameters:
ADDR_W, 32, byte-address width of fetch_addr and load_base
DEPTH, 256, number of words; must be a power of 2, at least 4
DATA_W, 32, instruction word width
NOP_WORD, 32'h00000013, fill value written by CLEAR (addi x0,x0,0)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
fetch_req  in  1  fetch request; accepted when fetch_ready=1
fetch_addr  in  ADDR_W  byte address; word index = fetch_addr[IW+1:2], where IW=$clog2(DEPTH)
fetch_ready  out  1  high only in RUN
fetch_valid  out  1  fetch_instr valid this cycle
fetch_instr  out  DATA_W  registered instruction
load_start  in  1  start a load; sampled in RUN only
load_base  in  ADDR_W  byte start address; bits [1:0] ignored
load_len  in  $clog2(DEPTH)+1  word count, 0..DEPTH
load_valid  in  1  load_data valid
load_data  in  DATA_W  word to write
load_ready  out  1  high only in LOAD
load_done  out  1  1-cycle pulse when a load completes
busy  out  1  state != RUN

Behaviour:
- Reset is synchronous and active-high (signal reset), on clock clk.
- Reset values: state=CLEAR, clear counter=0, fetch_valid=0, fetch_instr=NOP_WORD, load_done=0, load_ready=0, busy=1, fetch_ready=0.
- CLEAR:
  - Writes mem[cnt]=NOP_WORD each cycle, cnt=0..DEPTH-1.
  - After the cycle that writes DEPTH-1, go to RUN. CLEAR therefore lasts exactly DEPTH cycles.
  - fetch_req and load_start are ignored.
- RUN:
  - A fetch_req issued in cycle N gives fetch_valid=1 and fetch_instr=mem[idx] in cycle N+1.
  - fetch_valid=0 in every cycle after a cycle with no accepted request. fetch_instr holds its last value.
  - Back-to-back requests give one result per cycle.
  - Address bits above IW+1 are ignored, so addresses wrap modulo DEPTH*4.
- load_start in RUN:
  - If load_len==0: load_done=1 next cycle, state stays RUN.
  - Otherwise: ptr=load_base[IW+1:2], remaining=load_len, go to LOAD.
  - A fetch_req in the same cycle is still accepted and returns the pre-load contents.
- LOAD:
  - load_ready=1, fetch_ready=0; fetch_req is ignored and fetch_valid stays 0.
  - Each beat (load_valid and load_ready) writes mem[ptr]=load_data, then ptr=ptr+1 modulo DEPTH and remaining--.
  - Gaps in load_valid are allowed.
  - On the beat with remaining==1: go to RUN, and load_done=1 in the following cycle (the first RUN cycle).
  - load_len==DEPTH overwrites every word exactly once.
- load_start is ignored in CLEAR and LOAD. load_len and load_base are sampled only on an accepted load_start.
- Reset mid-LOAD or mid-CLEAR aborts the operation:
  - State returns to CLEAR and the whole array is refilled with NOP_WORD.
  - No load_done is produced for the aborted load.

Optional Feature:
IMEM_FAULT_EN:
- When defined, adds output fetch_fault (1 bit, reset 0), registered alongside fetch_valid.
- fetch_fault=1 for an accepted fetch when fetch_addr[1:0]!=0 or fetch_addr >= DEPTH*4.
- On a fault, fetch_instr=NOP_WORD and the memory is not read.
- When not defined, the port is absent, misaligned low bits are dropped and high bits wrap as described above.

Test Plan:
1. Assert reset for 1 cycle, then release -> busy=1 for exactly 256 cycles, then fetch_ready=1; fetch 0x000 -> next cycle fetch_valid=1, fetch_instr=0x00000013.
2. load_start with base=0x010, len=3; stream 0x00500113, 0x00C00193, 0xFF718393 with a 2-cycle valid gap -> load_done pulses once. Then fetches of 0x010, 0x014, 0x018 issued back-to-back return those words on 3 consecutive cycles.
3. Wrap: base=0x3FC, len=2, data 0xAAAA0001, 0xAAAA0002 -> fetch 0x3FC returns 0xAAAA0001, fetch 0x000 returns 0xAAAA0002.
4. Hold fetch_req high during LOAD -> fetch_valid=0 throughout. load_start in the same cycle as fetch 0x010 -> the fetch returns the old word. load_len=0 -> load_done pulses the next cycle and busy never rises.
5. Reset after 1 of 4 load beats -> CLEAR runs for 256 cycles, no load_done; fetch of the loaded address returns 0x00000013.
6. (IMEM_FAULT_EN) Fetch 0x002 -> fetch_fault=1 with instr 0x00000013. Fetch 0x400 -> fetch_fault=1. Fetch 0x3FC -> fetch_fault=0.
